// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Contents:
//   ST_IDLE / ST_RUN / ST_DONE : state encodings
//   state_e                    : FSM state type built on those encodings
//   count_width()              : bit-counter width, max(1, clog2(width))
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    // The counter only has to reach width-1, so clog2 suffices; keep at least one bit.
    function automatic int unsigned count_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full-adder cell, reused every cycle by the serial adder.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first using a single
// full-adder cell over WIDTH cycles.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_a, in_b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
//   busy                : high while an operation is running or its result is pending
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic [CW-1:0]    count;
    logic             cell_s;
    logic             cell_c;

    fullAdder u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_c)
    );

    // Sum fills from the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    always_comb begin
        sum_shift            = sum_sr >> 1;
        sum_shift[WIDTH-1]   = cell_s;
    end

    assign in_ready = (state == StIdle);
    assign sum      = sum_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            cout      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_sr  <= in_a;
                        b_sr  <= in_b;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    sum_sr <= sum_shift;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= cell_c;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        cout      <= cell_c;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed tests on WIDTH=8 plus
// random regressions on WIDTH=1 and WIDTH=16. Expected results go into per-DUT
// queues at acceptance; monitors pop and compare on each output handshake.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- WIDTH=8 DUT (directed) ----------------
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic [8:0] q8[$];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // ---------------- WIDTH=1 and WIDTH=16 DUTs (random) ----------------
    logic        rst_r;
    logic        iv1, ir1, ci1, ov1, or1, co1, bz1;
    logic [0:0]  a1, b1, s1;
    logic        iv16, ir16, ci16, ov16, or16, co16, bz16;
    logic [15:0] a16, b16, s16;
    logic [1:0]  q1[$];
    logic [16:0] q16[$];

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_r),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .in_a      (a1),
        .in_b      (b1),
        .cin       (ci1),
        .out_valid (ov1),
        .out_ready (or1),
        .sum       (s1),
        .cout      (co1),
        .busy      (bz1)
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_r),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .in_a      (a16),
        .in_b      (b16),
        .cin       (ci16),
        .out_valid (ov16),
        .out_ready (or16),
        .sum       (s16),
        .cout      (co16),
        .busy      (bz16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected progress", name);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q8.size() == 0) note_fail("w8_unexpected_output");
            else check("w8_result", {23'd0, cout, sum}, {23'd0, q8.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (rst_r && ov1 && or1) begin
            if (q1.size() == 0) note_fail("w1_unexpected_output");
            else check("w1_result", {30'd0, co1, s1}, {30'd0, q1.pop_front()});
        end
        if (rst_r && ov16 && or16) begin
            if (q16.size() == 0) note_fail("w16_unexpected_output");
            else check("w16_result", {15'd0, co16, s16}, {15'd0, q16.pop_front()});
        end
    end

    // ---------------- WIDTH=8 helpers (called at posedge+#1) ----------------
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        cin      = c;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            note_fail("w8_send");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (!(in_ready && q8.size() == 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("w8_idle", {31'd0, in_ready && q8.size() == 0}, 32'd1);
    endtask

    // Counts edges from the current point until out_valid rises.
    task automatic wait_valid8(input string name);
        int lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check(name, lat, 32'd8);
    endtask

    task automatic directed();
        int seen;
        // Reset state
        check("rst_state", {27'd0, in_ready, out_valid, busy, cout, (sum != 8'd0)}, 32'b10000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 0x5A + 0x3C = 0x96, latency and return to IDLE
        out_ready = 1'b1;
        send8(8'h5A, 8'h3C, 1'b0);
        check("busy_run", {30'd0, busy, in_ready}, 32'b10);
        wait_valid8("latency_5a3c");
        @(posedge clk); #1;
        check("back_idle", {30'd0, in_ready, out_valid}, 32'b10);

        // Carry chains
        send8(8'hFF, 8'h01, 1'b0);
        wait_idle8();
        send8(8'hFF, 8'hFF, 1'b1);
        wait_idle8();

        // Backpressure holds DONE stable
        out_ready = 1'b0;
        send8(8'h12, 8'h34, 1'b0);
        wait_valid8("latency_bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {21'd0, out_valid, in_ready, busy, cout, sum}, {21'd0, 3'b101, 1'b0, 8'h46});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

        // in_valid held with new operands during RUN/DONE must be ignored
        out_ready = 1'b0;
        send8(8'h0F, 8'h01, 1'b0);
        in_valid = 1'b1;
        in_a     = 8'h11;
        in_b     = 8'h22;
        cin      = 1'b0;
        wait_valid8("latency_hold");
        repeat (2) @(posedge clk);
        #1;
        check("hold_first", {23'd0, cout, sum}, 32'h010);
        out_ready = 1'b1;
        q8.push_back(9'h033);
        @(posedge clk); #1;
        check("hold_idle", {30'd0, in_ready, busy}, 32'b10);
        @(posedge clk); #1;
        check("hold_second_accept", {30'd0, busy, in_ready}, 32'b10);
        in_valid = 1'b0;
        wait_idle8();

        // Reset at RUN count=4 drops the operation
        send8(8'h77, 8'h11, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(q8.pop_back());
        @(posedge clk); #1;
        check("mid_reset", {27'd0, in_ready, out_valid, busy, cout, (sum != 8'd0)}, 32'b10000);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        check("no_valid_after_reset", seen, 32'd0);
        send8(8'h03, 8'h04, 1'b0);
        wait_idle8();
    endtask

    // ---------------- random regressions ----------------
    task automatic regress1();
        int n;
        logic a, b, c;
        for (int i = 0; i < 1000; i++) begin
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            iv1 = 1'b1; a1 = a; b1 = b; ci1 = c;
            n = 0;
            while (!ir1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!ir1) begin
                note_fail("w1_send");
            end else begin
                @(posedge clk);
                q1.push_back({1'b0, a} + {1'b0, b} + {1'b0, c});
                #1;
            end
            iv1 = 1'b0;
        end
        n = 0;
        while (q1.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("w1_drain", q1.size(), 32'd0);
    endtask

    task automatic regress16();
        int n;
        logic [15:0] a, b;
        logic c;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            iv16 = 1'b1; a16 = a; b16 = b; ci16 = c;
            n = 0;
            while (!ir16 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            if (!ir16) begin
                note_fail("w16_send");
            end else begin
                @(posedge clk);
                q16.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
                #1;
            end
            iv16 = 1'b0;
        end
        n = 0;
        while (q16.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("w16_drain", q16.size(), 32'd0);
    endtask

    initial begin
        or1  = 1'b0;
        or16 = 1'b0;
        forever begin
            @(posedge clk); #1;
            or1  = 1'($urandom_range(0, 1));
            or16 = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rst_r = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; cin = 1'b0; out_ready = 1'b0;
        iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_r = 1'b1;
        fork
            directed();
            regress1();
            regress16();
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
